// File: rtl/axi_rd_arbiter_if.sv
// Bundle of the upstream (s_*) and downstream (m_*) AXI4 read channels of axi_rd_arbiter.
// The arbiter uses the master modport; the environment around it uses the slave modport.
interface axi_rd_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 256
);
    localparam int SEL_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]        s_arready;
    logic [NUM_REQ-1:0]        s_arvalid;
    logic [NUM_REQ*ID_W-1:0]   s_arid;
    logic [NUM_REQ*ADDR_W-1:0] s_araddr;
    logic [NUM_REQ*8-1:0]      s_arlen;
    logic [NUM_REQ-1:0]        s_rready;
    logic [NUM_REQ-1:0]        s_rvalid;
    logic [NUM_REQ*ID_W-1:0]   s_rid;
    logic [NUM_REQ*DATA_W-1:0] s_rdata;
    logic [NUM_REQ*2-1:0]      s_rresp;
    logic [NUM_REQ-1:0]        s_rlast;

    logic                      m_arready;
    logic                      m_arvalid;
    logic [ID_W+SEL_W-1:0]     m_arid;
    logic [ADDR_W-1:0]         m_araddr;
    logic [7:0]                m_arlen;
    logic                      m_rready;
    logic                      m_rvalid;
    logic [ID_W+SEL_W-1:0]     m_rid;
    logic [DATA_W-1:0]         m_rdata;
    logic [1:0]                m_rresp;
    logic                      m_rlast;

    modport master (
        input  s_arvalid, s_arid, s_araddr, s_arlen, s_rready,
        input  m_arready, m_rvalid, m_rid, m_rdata, m_rresp, m_rlast,
        output s_arready, s_rvalid, s_rid, s_rdata, s_rresp, s_rlast,
        output m_arvalid, m_arid, m_araddr, m_arlen, m_rready
    );

    modport slave (
        output s_arvalid, s_arid, s_araddr, s_arlen, s_rready,
        output m_arready, m_rvalid, m_rid, m_rdata, m_rresp, m_rlast,
        input  s_arready, s_rvalid, s_rid, s_rdata, s_rresp, s_rlast,
        input  m_arvalid, m_arid, m_araddr, m_arlen, m_rready
    );
endinterface

// File: rtl/axi_rd_arbiter.sv
// Round-robin AXI4 read arbiter: NUM_REQ requesters share one read port; the AR stage is
// registered and tagged with the requester index, R beats are steered back by that tag.
module axi_rd_arbiter #(
    parameter int NUM_REQ   = 2,
    parameter int ID_W      = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 256,
    parameter int MAX_OUTST = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    axi_rd_arbiter_if.master   bus
);
    localparam int SEL_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int SEL_N = 1 << SEL_W;
    localparam int CNT_W = $clog2(MAX_OUTST + 1);

    logic [NUM_REQ-1:0]    elig_s;
    logic [NUM_REQ-1:0]    gnt_s;
    logic [SEL_W-1:0]      gnt_idx_s;
    logic [SEL_W-1:0]      cand_s;
    logic                  gnt_any_s;
    logic                  load_ok_s;
    logic                  accept_s;

    logic                  m_arvalid_q, m_arvalid_d;
    logic [ID_W+SEL_W-1:0] m_arid_q, m_arid_d;
    logic [ADDR_W-1:0]     m_araddr_q, m_araddr_d;
    logic [7:0]            m_arlen_q, m_arlen_d;
    logic [SEL_W-1:0]      rr_ptr_q, rr_ptr_d;

    logic [CNT_W-1:0]      outst_q [NUM_REQ];
    logic [CNT_W-1:0]      outst_d [NUM_REQ];
    logic [NUM_REQ-1:0]    inc_s;
    logic [NUM_REQ-1:0]    dec_s;

    logic [SEL_W-1:0]      sel_s;
    logic [SEL_N-1:0]      rready_pad_s;
    logic                  m_rready_s;
    logic [NUM_REQ-1:0]    s_rvalid_s;
    logic                  rdone_s;

    // Requester eligibility: a pending AR and room under its in-flight limit.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            elig_s[i] = bus.s_arvalid[i] && (outst_q[i] < CNT_W'(MAX_OUTST));
        end
    end

    // Round-robin search over eligible requesters starting at rr_ptr.
    always_comb begin
        gnt_s     = '0;
        gnt_idx_s = '0;
        gnt_any_s = 1'b0;
        cand_s    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_s = SEL_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (!gnt_any_s && elig_s[cand_s]) begin
                gnt_s[cand_s] = 1'b1;
                gnt_idx_s     = cand_s;
                gnt_any_s     = 1'b1;
            end else begin
                gnt_any_s     = gnt_any_s;
            end
        end
    end

    assign load_ok_s = !m_arvalid_q || bus.m_arready;
    assign accept_s  = gnt_any_s && load_ok_s && rst_n;

    // Next state of the AR output stage and the round-robin pointer.
    always_comb begin
        m_arvalid_d = m_arvalid_q;
        m_arid_d    = m_arid_q;
        m_araddr_d  = m_araddr_q;
        m_arlen_d   = m_arlen_q;
        rr_ptr_d    = rr_ptr_q;
        if (accept_s) begin
            m_arvalid_d = 1'b1;
            m_arid_d    = {gnt_idx_s, bus.s_arid[gnt_idx_s*ID_W +: ID_W]};
            m_araddr_d  = bus.s_araddr[gnt_idx_s*ADDR_W +: ADDR_W];
            m_arlen_d   = bus.s_arlen[gnt_idx_s*8 +: 8];
            rr_ptr_d    = SEL_W'((int'(gnt_idx_s) + 1) % NUM_REQ);
        end else if (bus.m_arready) begin
            m_arvalid_d = 1'b0;
        end else begin
            m_arvalid_d = m_arvalid_q;
        end
    end

    // R steering; tags beyond NUM_REQ see a padded ready of 1 so stray beats drain.
    always_comb begin
        sel_s        = bus.m_rid[ID_W+SEL_W-1:ID_W];
        rready_pad_s = '1;
        for (int i = 0; i < NUM_REQ; i++) begin
            rready_pad_s[i] = bus.s_rready[i];
            s_rvalid_s[i]   = bus.m_rvalid && (sel_s == SEL_W'(i));
        end
        m_rready_s = rready_pad_s[sel_s];
    end

    assign rdone_s = bus.m_rvalid && m_rready_s && bus.m_rlast;

    // Outstanding counters: simultaneous accept and burst completion cancel out.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            inc_s[i] = accept_s && (gnt_idx_s == SEL_W'(i));
            dec_s[i] = rdone_s && (sel_s == SEL_W'(i)) && (outst_q[i] != '0);
            case ({inc_s[i], dec_s[i]})
                2'b10:   outst_d[i] = outst_q[i] + CNT_W'(1);
                2'b01:   outst_d[i] = outst_q[i] - CNT_W'(1);
                default: outst_d[i] = outst_q[i];
            endcase
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_arvalid_q <= 1'b0;
            m_arid_q    <= '0;
            m_araddr_q  <= '0;
            m_arlen_q   <= 8'h00;
            rr_ptr_q    <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                outst_q[i] <= '0;
            end
        end else begin
            m_arvalid_q <= m_arvalid_d;
            m_arid_q    <= m_arid_d;
            m_araddr_q  <= m_araddr_d;
            m_arlen_q   <= m_arlen_d;
            rr_ptr_q    <= rr_ptr_d;
            for (int i = 0; i < NUM_REQ; i++) begin
                outst_q[i] <= outst_d[i];
            end
        end
    end

    assign bus.s_arready = gnt_s & {NUM_REQ{load_ok_s && rst_n}};
    assign bus.m_arvalid = m_arvalid_q;
    assign bus.m_arid    = m_arid_q;
    assign bus.m_araddr  = m_araddr_q;
    assign bus.m_arlen   = m_arlen_q;
    assign bus.m_rready  = m_rready_s;
    assign bus.s_rvalid  = s_rvalid_s;
    assign bus.s_rid     = {NUM_REQ{bus.m_rid[ID_W-1:0]}};
    assign bus.s_rdata   = {NUM_REQ{bus.m_rdata}};
    assign bus.s_rresp   = {NUM_REQ{bus.m_rresp}};
    assign bus.s_rlast   = {NUM_REQ{bus.m_rlast}};
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: instance A (MAX_OUTST=16) covers reset, fairness and
// backpressure; instance B (MAX_OUTST=2) covers in-flight limits and R steering.
module tb_axi_rd_arbiter;
    logic clk;
    logic rst_n;
    int   n_total;
    int   n_pass;

    axi_rd_arbiter_if #(.NUM_REQ(2), .ID_W(4), .ADDR_W(32), .DATA_W(256)) ifa ();
    axi_rd_arbiter_if #(.NUM_REQ(2), .ID_W(4), .ADDR_W(32), .DATA_W(32))  ifb ();

    axi_rd_arbiter #(.NUM_REQ(2), .ID_W(4), .ADDR_W(32), .DATA_W(256), .MAX_OUTST(16)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa)
    );

    axi_rd_arbiter #(.NUM_REQ(2), .ID_W(4), .ADDR_W(32), .DATA_W(32), .MAX_OUTST(2)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int acc0;
        int acc1;
        int beat;
        logic rr1;
        n_total = 0;
        n_pass  = 0;
        acc0    = 0;
        acc1    = 0;
        rst_n   = 1'b0;

        ifa.s_arvalid = 2'b11;
        ifa.s_arid    = {4'h9, 4'h3};
        ifa.s_araddr  = {32'h0000_2000, 32'h0000_1000};
        ifa.s_arlen   = {8'h07, 8'h03};
        ifa.s_rready  = 2'b11;
        ifa.m_arready = 1'b1;
        ifa.m_rvalid  = 1'b0;
        ifa.m_rid     = 5'h00;
        ifa.m_rdata   = '0;
        ifa.m_rresp   = 2'b00;
        ifa.m_rlast   = 1'b0;

        ifb.s_arvalid = 2'b00;
        ifb.s_arid    = {4'h5, 4'h2};
        ifb.s_araddr  = {32'h0000_B000, 32'h0000_A000};
        ifb.s_arlen   = {8'h00, 8'h00};
        ifb.s_rready  = 2'b11;
        ifb.m_arready = 1'b1;
        ifb.m_rvalid  = 1'b0;
        ifb.m_rid     = 5'h00;
        ifb.m_rdata   = 32'h0;
        ifb.m_rresp   = 2'b00;
        ifb.m_rlast   = 1'b0;

        // Reset held three cycles with both requesters asking.
        for (int c = 0; c < 3; c++) begin
            tick();
            check_eq("rst_arready", 64'(ifa.s_arready), 64'h0);
            check_eq("rst_arvalid", 64'(ifa.m_arvalid), 64'h0);
            check_eq("rst_arid", 64'(ifa.m_arid), 64'h0);
        end
        rst_n = 1'b1;
        #1;
        check_eq("first_gnt", 64'(ifa.s_arready), 64'h1);

        // Fairness: eight back-to-back accepts alternate 0,1,0,1...
        for (int k = 0; k < 8; k++) begin
            tick();
            check_eq("fair_arvalid", 64'(ifa.m_arvalid), 64'h1);
            check_eq("fair_arid", 64'(ifa.m_arid), (k % 2 == 1) ? 64'h19 : 64'h03);
            check_eq("fair_araddr", 64'(ifa.m_araddr), (k % 2 == 1) ? 64'h2000 : 64'h1000);
            if (ifa.m_arvalid === 1'b1) begin
                if (ifa.m_arid[4] === 1'b1) acc1++;
                else acc0++;
            end
        end
        ifa.s_arvalid = 2'b00;
        check_eq("fair_acc0", 64'(acc0), 64'd4);
        check_eq("fair_acc1", 64'(acc1), 64'd4);
        tick();
        check_eq("drain_arvalid", 64'(ifa.m_arvalid), 64'h0);

        // Backpressure: stage held, payload stable, pointer parked on requester 1.
        ifa.m_arready = 1'b0;
        ifa.s_arvalid = 2'b11;
        #1;
        check_eq("bp_first_gnt", 64'(ifa.s_arready), 64'h1);
        tick();
        for (int c = 0; c < 5; c++) begin
            check_eq("bp_arready", 64'(ifa.s_arready), 64'h0);
            check_eq("bp_arvalid", 64'(ifa.m_arvalid), 64'h1);
            check_eq("bp_arid", 64'(ifa.m_arid), 64'h03);
            check_eq("bp_araddr", 64'(ifa.m_araddr), 64'h1000);
            check_eq("bp_arlen", 64'(ifa.m_arlen), 64'h03);
            tick();
        end
        ifa.m_arready = 1'b1;
        #1;
        check_eq("bp_next_gnt", 64'(ifa.s_arready), 64'h2);
        tick();
        check_eq("bp_next_arid", 64'(ifa.m_arid), 64'h19);
        check_eq("bp_next_arlen", 64'(ifa.m_arlen), 64'h07);
        ifa.s_arvalid = 2'b00;
        tick();
        check_eq("bp_drain", 64'(ifa.m_arvalid), 64'h0);

        // Outstanding limit of 2 on requester 0.
        ifb.s_arvalid = 2'b01;
        #1;
        check_eq("lim_gnt1", 64'(ifb.s_arready), 64'h1);
        tick();
        check_eq("lim_gnt2", 64'(ifb.s_arready), 64'h1);
        tick();
        check_eq("lim_stall", 64'(ifb.s_arready), 64'h0);
        tick();
        check_eq("lim_stall2", 64'(ifb.s_arready), 64'h0);
        check_eq("lim_arvalid", 64'(ifb.m_arvalid), 64'h0);
        ifb.m_rvalid = 1'b1;
        ifb.m_rlast  = 1'b1;
        ifb.m_rid    = 5'h02;
        #1;
        check_eq("lim_rready", 64'(ifb.m_rready), 64'h1);
        check_eq("lim_rvalid", 64'(ifb.s_rvalid), 64'h1);
        check_eq("lim_same_cyc", 64'(ifb.s_arready), 64'h0);
        tick();
        ifb.m_rvalid = 1'b0;
        #1;
        check_eq("lim_release", 64'(ifb.s_arready), 64'h1);
        tick();
        check_eq("lim_arvalid3", 64'(ifb.m_arvalid), 64'h1);
        check_eq("lim_arid3", 64'(ifb.m_arid), 64'h02);
        ifb.s_arvalid = 2'b00;

        // Accept and burst completion for requester 1 in the same cycle at count 1.
        ifb.s_arvalid = 2'b10;
        #1;
        check_eq("sim_gnt1", 64'(ifb.s_arready), 64'h2);
        tick();
        ifb.m_rvalid = 1'b1;
        ifb.m_rlast  = 1'b1;
        ifb.m_rid    = 5'h15;
        #1;
        check_eq("sim_gnt2", 64'(ifb.s_arready), 64'h2);
        check_eq("sim_rready", 64'(ifb.m_rready), 64'h1);
        tick();
        ifb.m_rvalid = 1'b0;
        #1;
        check_eq("sim_count1", 64'(ifb.s_arready), 64'h2);
        tick();
        check_eq("sim_count2", 64'(ifb.s_arready), 64'h0);

        // R steering: 4-beat burst to requester 1 with toggling ready.
        beat = 0;
        ifb.m_rid = 5'h15;
        for (int c = 0; c < 7; c++) begin
            rr1 = (c % 2 == 0);
            ifb.s_rready = {rr1, 1'b1};
            ifb.m_rvalid = 1'b1;
            ifb.m_rlast  = (beat == 3);
            ifb.m_rdata  = 32'hD000_0000 + 32'(beat);
            #1;
            check_eq("r_svalid", 64'(ifb.s_rvalid), 64'h2);
            check_eq("r_mrready", 64'(ifb.m_rready), 64'(rr1));
            check_eq("r_rid", 64'(ifb.s_rid[4 +: 4]), 64'h5);
            check_eq("r_rdata", 64'(ifb.s_rdata[32 +: 32]), 64'hD000_0000 + 64'(beat));
            check_eq("r_no_dec", 64'(ifb.s_arready), 64'h0);
            tick();
            if (rr1) beat++;
        end
        ifb.m_rvalid = 1'b0;
        ifb.m_rlast  = 1'b0;
        ifb.s_rready = 2'b11;
        #1;
        check_eq("r_beats", 64'(beat), 64'd4);
        check_eq("r_dec_last", 64'(ifb.s_arready), 64'h2);
        check_eq("r_idle", 64'(ifb.s_rvalid), 64'h0);
        ifb.s_arvalid = 2'b00;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
